dmem_pipe: RTL

Parametrised, pipelined data memory for the core's load/store path. It supersedes the single-cycle data memory: same access-type encoding (byte/half/word, signed/unsigned), plus a valid/ready request handshake, a configurable registered read latency, response back-pressure, per-byte write enables and alignment/range error reporting. It sits between the MEM stage and the word-organised data RAM.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_lane_fmt.sv | 43 ++++
 rtl/dmem_pipe.sv | 94 +++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and pipeline stage record for the pipelined data memory.
package dmem_pkg;

  localparam logic [1:0] TYPE_B = 2'b00;
  localparam logic [1:0] TYPE_H = 2'b01;
  localparam logic [1:0] TYPE_W = 2'b10;
  localparam logic [1:0] TYPE_X = 2'b11;

  // Bit of the access type that selects zero-extension on loads
  localparam int TYPE_UNS_BIT = 2;

  // Control half of a pipeline stage; the raw RAM word travels in a parallel
  // register chain so the first word register can be the RAM output register.
  typedef struct packed {
    logic       valid;
    logic       we;
    logic       err;
    logic [2:0] typ;
    logic [1:0] off;
  } stage_ctl_t;

  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
    return (size == TYPE_H && off[0]) || (size == TYPE_W && off != 2'b00) || (size == TYPE_X);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and the pipelined data memory.
interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_type;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_type, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_type, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Lane formatting: store byte enables/replication and load lane extract/extend.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  assign w_byte = i_data[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_data[31:16] : i_data[15:0];
  assign w_sext = ~i_type[TYPE_UNS_BIT];

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_type[1:0])
      TYPE_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_data[7:0]}};
        o_rdata = {{24{w_sext & w_byte[7]}}, w_byte};
      end
      TYPE_H: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_data[15:0]}};
        o_rdata = {{16{w_sext & w_half[15]}}, w_half};
      end
      TYPE_W: begin
        o_be    = 4'b1111;
        o_wdata = i_data;
        o_rdata = i_data;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_pipe.sv
// Pipelined byte-enable data memory with valid/ready request and response
// handshakes, READ_LAT-stage response pipeline and access error reporting.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem  [DEPTH_WORDS];
  stage_ctl_t  r_ctl  [READ_LAT];
  logic [31:0] r_word [READ_LAT];

  stage_ctl_t       w_last;
  logic             w_adv, w_accept, w_oor, w_err, w_wr_en, w_rd_en;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep, w_ext;
  logic [31:0]      w_unused_st_rdata, w_unused_ld_wdata;
  logic [3:0]       w_unused_ld_be;

  // The whole pipeline advances together; a held response freezes every stage.
  assign w_last        = r_ctl[READ_LAT-1];
  assign w_adv         = !(w_last.valid && !bus.resp_ready);
  assign bus.req_ready = w_adv;
  assign w_accept      = bus.req_valid && w_adv;

  assign w_idx = bus.req_addr[IDX_W+1:2];
  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign w_oor = |bus.req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_full
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_err   = w_oor || bad_access(bus.req_type[1:0], bus.req_addr[1:0]);
  assign w_wr_en = w_accept && bus.req_we && !w_err;
  assign w_rd_en = w_accept && !bus.req_we && !w_err;

  dmem_lane_fmt u_st_fmt (
    .i_type  (bus.req_type),
    .i_off   (bus.req_addr[1:0]),
    .i_data  (bus.req_wdata),
    .o_be    (w_be),
    .o_wdata (w_wdata_rep),
    .o_rdata (w_unused_st_rdata)
  );

  dmem_lane_fmt u_ld_fmt (
    .i_type  (w_last.typ),
    .i_off   (w_last.off),
    .i_data  (r_word[READ_LAT-1]),
    .o_be    (w_unused_ld_be),
    .o_wdata (w_unused_ld_wdata),
    .o_rdata (w_ext)
  );

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
  end

  // Word chain is data-only (no reset); validity comes from the control chain.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      if (w_rd_en) r_word[0] <= r_mem[w_idx];
      for (int s = 1; s < READ_LAT; s++) r_word[s] <= r_word[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < READ_LAT; s++) r_ctl[s] <= '0;
    end else if (w_adv) begin
      r_ctl[0] <= '{valid: w_accept, we: bus.req_we, err: w_err,
                    typ: bus.req_type, off: bus.req_addr[1:0]};
      for (int s = 1; s < READ_LAT; s++) r_ctl[s] <= r_ctl[s-1];
    end
  end

  assign bus.resp_valid = w_last.valid;
  assign bus.resp_err   = w_last.valid && w_last.err;
  assign bus.resp_rdata = (w_last.valid && !w_last.we && !w_last.err) ? w_ext : 32'h0;
endmodule
